// File: rtl/ex_stage.sv
// Execute stage: logic, shift, move and HI/LO operations with a one-cycle
// registered result towards MEM. Supports stall (hold) and flush (bubble).
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [7:0]  aluOp,
    input  logic [31:0] opNum1,
    input  logic [31:0] opNum2,
    input  logic        writeReg,
    input  logic [4:0]  writeAddr,
    output logic        ex_writeReg,
    output logic [4:0]  ex_writeAddr,
    output logic [31:0] ex_wdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_MOVZ_OP = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP = 8'b0000_1011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;

    logic        wreg_q, wreg_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  shamt;

    assign shamt = opNum1[4:0];

    always_comb begin
        wdata_d = '0;
        wreg_d  = writeReg;
        waddr_d = writeAddr;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (aluOp)
            EXE_OR_OP:   wdata_d = opNum1 | opNum2;
            EXE_AND_OP:  wdata_d = opNum1 & opNum2;
            EXE_XOR_OP:  wdata_d = opNum1 ^ opNum2;
            EXE_NOR_OP:  wdata_d = ~(opNum1 | opNum2);
            EXE_SLL_OP:  wdata_d = opNum2 << shamt;
            EXE_SRL_OP:  wdata_d = opNum2 >> shamt;
            EXE_SRA_OP:  wdata_d = $unsigned($signed(opNum2) >>> shamt);
            EXE_MOVN_OP,
            EXE_MOVZ_OP: wdata_d = opNum1;
            EXE_MFHI_OP: wdata_d = hi_q;
            EXE_MFLO_OP: wdata_d = lo_q;
            EXE_MTHI_OP: hi_d    = opNum1;
            EXE_MTLO_OP: lo_d    = opNum1;
            default:     wreg_d  = 1'b0;
        endcase
    end

    // Flush clears the result registers but leaves HI/LO untouched,
    // which is how a squashed MTHI/MTLO gets suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreg_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (flush) begin
            wreg_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (!stall) begin
            wreg_q  <= wreg_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign ex_writeReg  = wreg_q;
    assign ex_writeAddr = waddr_q;
    assign ex_wdata     = wdata_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high (`RstEnable`).
REQ-003 SHALL have port stall, input, 1 bit: 1 = hold all state this edge.
REQ-004 SHALL have port flush, input, 1 bit: 1 = load a bubble this edge.
REQ-005 SHALL have port aluOp, input, `AluOpLength`: operation from decode.
REQ-006 SHALL have port opNum1, input, 32 bits: operand 1 from decode.
REQ-007 SHALL have port opNum2, input, 32 bits: operand 2 from decode.
REQ-008 SHALL have port writeReg, input, 1 bit: decode write enable.
REQ-009 SHALL have port writeAddr, input, 5 bits: decode destination register.
REQ-010 SHALL have port ex_writeReg, output, 1 bit: registered write enable to MEM.
REQ-011 SHALL have port ex_writeAddr, output, 5 bits: registered destination to MEM.
REQ-012 SHALL have port ex_wdata, output, 32 bits: registered result to MEM.
REQ-013 SHALL have port hi_o, output, 32 bits: current HI register.
REQ-014 SHALL have port lo_o, output, 32 bits: current LO register.

Function
REQ-015 SHALL compute the result combinationally from aluOp/opNum1/opNum2 and register it with writeReg/writeAddr on the next rising edge (latency 1 cycle).
REQ-016 SHALL produce these results:
- EXE_OR_OP: opNum1 | opNum2.
- EXE_AND_OP: opNum1 & opNum2.
- EXE_XOR_OP: opNum1 ^ opNum2.
- EXE_NOR_OP: ~(opNum1 | opNum2).
REQ-017 SHALL take the shift amount from opNum1[4:0] and the shifted value from opNum2:
- EXE_SLL_OP: logical left.
- EXE_SRL_OP: logical right, zero fill.
- EXE_SRA_OP: arithmetic right, fill with opNum2[31].
- Amount 0: opNum2 unchanged. Amount 31 with SRA of 0x80000000: 0xFFFFFFFF.
REQ-018 SHALL produce opNum1 for EXE_MOVN_OP and EXE_MOVZ_OP; the write condition is taken from writeReg as supplied and is not re-evaluated here.
REQ-019 SHALL produce hi_o for EXE_MFHI_OP and lo_o for EXE_MFLO_OP, using register contents at the time of the edge.
REQ-020 SHALL load HI <= opNum1 on an edge with EXE_MTHI_OP, and LO <= opNum1 on an edge with EXE_MTLO_OP; no other op alters HI/LO.
REQ-021 SHALL make a value written by MTHI/MTLO visible on hi_o/lo_o from the cycle after the edge, so an MFHI in the next cycle returns the new value.
REQ-022 SHALL produce result 0 for EXE_NOP_OP and any unlisted aluOp, and SHALL force ex_writeReg to 0 for these ops.
REQ-023 SHALL, when stall=1 and flush=0, hold ex_writeReg, ex_writeAddr, ex_wdata, HI and LO unchanged.
REQ-024 SHALL, when flush=1, load ex_writeReg=0, ex_writeAddr=0 and ex_wdata=0, and suppress HI/LO writes; flush has priority over stall.
REQ-025 SHALL be purely datapath plus registers: no handshake beyond stall/flush, no multi-cycle operations.

Reset
REQ-026 SHALL, while rst=1, immediately clear ex_writeReg, ex_writeAddr, ex_wdata, HI and LO to 0, independent of clk.
REQ-027 SHALL, if reset is asserted mid-operation, discard the pending result and any pending HI/LO write; the first edge after deassertion registers the current inputs normally.

Verification
REQ-028 Bench SHALL drive EXE_OR_OP, opNum1=0x0000FF00, opNum2=0x000000FF, writeReg=1, writeAddr=3 -> one edge later ex_wdata=0x0000FFFF, ex_writeReg=1, ex_writeAddr=3.
REQ-029 Bench SHALL drive EXE_SRA_OP with opNum1=4, opNum2=0x80000000 -> ex_wdata=0xF8000000; the same with EXE_SRL_OP -> 0x08000000; EXE_SLL_OP with opNum1=0 -> 0x80000000.
REQ-030 Bench SHALL drive EXE_MTHI_OP with opNum1=0x12345678, then EXE_MFHI_OP with writeAddr=5 on the next cycle -> hi_o=0x12345678 and ex_wdata=0x12345678 after the second edge; lo_o stays 0.
REQ-031 Bench SHALL hold stall=1 for 3 cycles while inputs change, including an EXE_MTLO_OP -> outputs and lo_o are frozen; then flush=1 together with stall=1 -> next edge gives ex_writeReg=0, ex_wdata=0.
REQ-032 Bench SHALL assert rst between clock edges after loading HI=0xA, with ex_wdata nonzero -> all outputs read 0 before the next edge; after release, EXE_NOR_OP with operands 0,0 -> 0xFFFFFFFF.
REQ-033 Bench SHALL drive an undefined aluOp with writeReg=1 -> ex_writeReg=0, ex_wdata=0.
